// File: rtl/frame_buffer_dbl_param_if.sv
// frame_buffer_dbl_param_if: draw, read and status signals of the double-buffered frame store
interface frame_buffer_dbl_param_if;
  logic        frame_clk_rising_edge;
  logic        frame_done;
  logic        clear_req;
  logic        draw_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [23:0] draw_data;
  logic [9:0]  ReadX;
  logic [9:0]  ReadY;
  logic [23:0] read_data;
  logic        front_sel;
  logic        swap_pending;
  logic        clear_busy;
  modport master (
    output frame_clk_rising_edge, frame_done, clear_req, draw_valid, DrawX, DrawY, draw_data, ReadX, ReadY,
    input  read_data, front_sel, swap_pending, clear_busy
  );
  modport slave (
    input  frame_clk_rising_edge, frame_done, clear_req, draw_valid, DrawX, DrawY, draw_data, ReadX, ReadY,
    output read_data, front_sel, swap_pending, clear_busy
  );
endinterface

// File: rtl/frame_buffer_dbl_param.sv
// frame_buffer_dbl_param: double-buffered viewport frame store with clear engine and bank-coherent read pipeline
module frame_buffer_dbl_param #(
  parameter int          ORIGIN_X     = 115,
  parameter int          ORIGIN_Y     = 80,
  parameter int          VIEW_W       = 410,
  parameter int          VIEW_H       = 320,
  parameter int          CBITS        = 4,
  parameter logic [23:0] KEY_COLOR    = 24'h000000,
  parameter logic [23:0] CLEAR_COLOR  = 24'h000000,
  parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  frame_buffer_dbl_param_if.slave bus
);
  localparam int DEPTH = VIEW_W * VIEW_H;
  localparam int AW = $clog2(DEPTH);
  localparam int WW = 3 * CBITS;
  localparam logic [0:0] IDLE = 1'b0, CLEAR = 1'b1;

  function automatic logic in_win(input logic [9:0] x, input logic [9:0] y);
    return int'(x) >= ORIGIN_X && int'(x) < ORIGIN_X + VIEW_W &&
           int'(y) >= ORIGIN_Y && int'(y) < ORIGIN_Y + VIEW_H;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [9:0] x, input logic [9:0] y);
    return AW'((int'(x) - ORIGIN_X) + (int'(y) - ORIGIN_Y) * VIEW_W);
  endfunction

  function automatic logic [WW-1:0] quant(input logic [23:0] c);
    return {c[23 -: CBITS], c[15 -: CBITS], c[7 -: CBITS]};
  endfunction

  function automatic logic [7:0] expand(input logic [CBITS-1:0] v);
    return 8'(v) << (8 - CBITS);
  endfunction

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          front_q, front_d, pend_q, pend_d;
  logic          busy, last, swap, draw_we, we;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata;
  logic [WW-1:0] mem0 [DEPTH];
  logic [WW-1:0] mem1 [DEPTH];
  logic [AW-1:0] raddr_q;
  logic          rwin1_q, rbank1_q, rwin2_q, rbank2_q;
  logic [WW-1:0] rq0_q, rq1_q, rsel;
  logic [23:0]   rdata_q;

  always_comb begin
    busy    = state_q == CLEAR;
    last    = cnt_q == AW'(DEPTH - 1);
    state_d = busy ? (last ? IDLE : CLEAR) : (bus.clear_req ? CLEAR : IDLE);
    cnt_d   = busy && !last ? cnt_q + 1'b1 : '0;
    swap    = bus.frame_clk_rising_edge && (pend_q || bus.frame_done) && !busy;
    front_d = front_q ^ swap;
    pend_d  = swap ? 1'b0 : (pend_q || bus.frame_done);
    draw_we = bus.draw_valid && in_win(bus.DrawX, bus.DrawY) && bus.draw_data != KEY_COLOR && !busy;
    we      = busy || draw_we;
    waddr   = busy ? cnt_q : addr_of(bus.DrawX, bus.DrawY);
    wdata   = busy ? quant(CLEAR_COLOR) : quant(bus.draw_data);
    rsel    = rbank2_q ? rq1_q : rq0_q;
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      raddr_q  <= '0;
      rwin1_q  <= 1'b0;
      rbank1_q <= 1'b0;
      rwin2_q  <= 1'b0;
      rbank2_q <= 1'b0;
      rdata_q  <= BORDER_COLOR;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      front_q  <= front_d;
      pend_q   <= pend_d;
      raddr_q  <= addr_of(bus.ReadX, bus.ReadY);
      rwin1_q  <= in_win(bus.ReadX, bus.ReadY);
      rbank1_q <= front_q;
      rwin2_q  <= rwin1_q;
      rbank2_q <= rbank1_q;
      rdata_q  <= rwin2_q ? {expand(rsel[WW-1 -: CBITS]), expand(rsel[2*CBITS-1 -: CBITS]),
                             expand(rsel[CBITS-1:0])} : BORDER_COLOR;
    end

  // Drawing and clearing always target the back bank; each RAM keeps a single write and read port.
  always_ff @(posedge Clk) begin
    if (we && front_q) mem0[waddr] <= wdata;
    if (we && !front_q) mem1[waddr] <= wdata;
    rq0_q <= mem0[raddr_q];
    rq1_q <= mem1[raddr_q];
  end

  assign bus.read_data    = rdata_q;
  assign bus.front_sel    = front_q;
  assign bus.swap_pending = pend_q;
  assign bus.clear_busy   = busy;
endmodule

// File: tb/tb_frame_buffer_dbl_param.sv
// tb_frame_buffer_dbl_param: randomized scoreboard bench against a pixel-level model of the frame store
module tb_frame_buffer_dbl_param;
  localparam int OX = 115, OY = 80, VW = 20, VH = 10, CB = 4, DEPTH = VW * VH;
  localparam logic [23:0] KEY = 24'h000000, CLR = 24'h5A3C96, BRD = 24'hFFFFFF;
  localparam logic [7:0] CM = 8'(8'hFF << (8 - CB));
  localparam logic [23:0] MASK = {CM, CM, CM};

  typedef struct {
    int          due;
    bit          chk;
    logic [23:0] exp;
  } item_t;

  logic Clk = 1'b0, Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  frame_buffer_dbl_param_if b();
  frame_buffer_dbl_param #(
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .VIEW_W(VW), .VIEW_H(VH), .CBITS(CB),
    .KEY_COLOR(KEY), .CLEAR_COLOR(CLR), .BORDER_COLOR(BRD)
  ) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(b));

  item_t sbq[$];
  int    vec = 0, miss = 0, cyc_n = 0;
  bit    front_m, pend_m, busy_m, s_v, s_win, s_bank, rd_hold;
  int    ccnt_m, s_addr;
  int    mem_m[2][DEPTH];

  function automatic bit inwin(input int x, input int y);
    return x >= OX && x < OX + VW && y >= OY && y < OY + VH;
  endfunction

  function automatic int aof(input int x, input int y);
    return (x - OX) + (y - OY) * VW;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pixel arrays per bank (-1 = never written), evaluated at each clock edge.
  initial begin
    foreach (mem_m[i, j]) mem_m[i][j] = -1;
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        front_m = 0; pend_m = 0; busy_m = 0; ccnt_m = 0; s_v = 0;
        sbq.delete();
      end else begin
        item_t it;
        bit    was_busy;
        cyc_n++;
        if (s_v) begin
          it.due = cyc_n + 1;
          it.chk = !s_win || mem_m[s_bank][s_addr] >= 0;
          it.exp = s_win ? 24'(mem_m[s_bank][s_addr]) : BRD;
          sbq.push_back(it);
        end
        s_v    = 1;
        s_win  = inwin(int'(b.ReadX), int'(b.ReadY));
        s_addr = s_win ? aof(int'(b.ReadX), int'(b.ReadY)) : 0;
        s_bank = front_m;
        was_busy = busy_m;
        if (busy_m) begin
          mem_m[!front_m][ccnt_m] = int'(CLR & MASK);
          ccnt_m++;
          if (ccnt_m == DEPTH) begin busy_m = 0; ccnt_m = 0; end
        end else if (b.draw_valid && inwin(int'(b.DrawX), int'(b.DrawY)) && b.draw_data != KEY)
          mem_m[!front_m][aof(int'(b.DrawX), int'(b.DrawY))] = int'(b.draw_data & MASK);
        if (!was_busy && b.clear_req) begin busy_m = 1; ccnt_m = 0; end
        if (b.frame_clk_rising_edge && (pend_m || b.frame_done) && !was_busy) begin
          front_m = !front_m; pend_m = 0;
        end else if (b.frame_done) pend_m = 1;
      end
    end
  end

  // Monitor: status every cycle, read_data whenever a scoreboard entry falls due.
  initial forever begin
    item_t it;
    @(negedge Clk);
    if (cyc_n > 0 || !Reset_n) begin
      chk("front_sel", b.front_sel, front_m);
      chk("swap_pending", b.swap_pending, pend_m);
      chk("clear_busy", b.clear_busy, busy_m);
    end
    while (sbq.size() > 0 && sbq[0].due <= cyc_n) begin
      it = sbq.pop_front();
      if (it.chk && it.due == cyc_n) chk("read_data", b.read_data, it.exp);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
    if (!rd_hold) begin
      b.ReadX = 10'(OX - 2 + $urandom_range(VW + 3));
      b.ReadY = 10'(OY - 2 + $urandom_range(VH + 3));
    end
  endtask

  task automatic clear_run(input string nm);
    int n = 0;
    b.clear_req = 1;
    cyc();
    b.clear_req = 0;
    while (b.clear_busy && n < 4 * DEPTH) begin
      b.draw_valid = 1;
      b.DrawX = 10'(OX + $urandom_range(VW - 1));
      b.DrawY = 10'(OY + $urandom_range(VH - 1));
      b.draw_data = 24'($urandom) | 24'h1;
      n++;
      cyc();
    end
    b.draw_valid = 0;
    chk(nm, n, DEPTH);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (b.clear_busy && n < 4 * DEPTH) begin n++; cyc(); end
    chk("clear_timeout", b.clear_busy, 0);
  endtask

  task automatic swap_now();
    bit f0 = b.front_sel;
    b.frame_done = 1;
    b.frame_clk_rising_edge = 1;
    cyc();
    b.frame_done = 0;
    b.frame_clk_rising_edge = 0;
    chk("swap_coinc", b.front_sel, !f0);
    chk("swap_coinc_pend", b.swap_pending, 0);
  endtask

  task automatic pulse_fce();
    b.frame_clk_rising_edge = 1;
    cyc();
    b.frame_clk_rising_edge = 0;
  endtask

  initial begin
    bit f0;
    {b.frame_clk_rising_edge, b.frame_done, b.clear_req, b.draw_valid} = '0;
    {b.DrawX, b.DrawY, b.ReadX, b.ReadY} = '0;
    b.draw_data = '0;
    rd_hold = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_read_data", b.read_data, BRD);
    chk("rst_front", b.front_sel, 0);
    chk("rst_busy", b.clear_busy, 0);
    Reset_n = 1;
    cyc();
    clear_run("clear_len_bank1");
    swap_now();
    clear_run("clear_len_bank0");
    b.frame_done = 1;
    cyc();
    b.frame_done = 0;
    chk("pend_set", b.swap_pending, 1);
    repeat (3) cyc();
    pulse_fce();
    chk("pend_swap_front", b.front_sel, 0);
    chk("pend_swap_clr", b.swap_pending, 0);
    // Window corners, pipelined back to back.
    rd_hold = 1;
    b.ReadX = 10'(OX - 1); b.ReadY = 10'(OY); cyc();
    b.ReadX = 10'(OX + VW - 1); b.ReadY = 10'(OY + VH - 1); cyc();
    b.ReadX = 10'(OX + VW); cyc();
    chk("corner_left", b.read_data, BRD);
    cyc();
    chk("corner_last", b.read_data, CLR & MASK);
    cyc();
    chk("corner_right", b.read_data, BRD);
    rd_hold = 0;
    // Quantised draw followed by a transparent draw to the same pixel.
    b.draw_valid = 1; b.DrawX = 10'(OX); b.DrawY = 10'(OY); b.draw_data = 24'hA5C3F0;
    cyc();
    b.draw_data = KEY;
    cyc();
    b.draw_valid = 0;
    swap_now();
    rd_hold = 1;
    b.ReadX = 10'(OX); b.ReadY = 10'(OY);
    repeat (3) cyc();
    chk("quant_pixel", b.read_data, 24'hA0C0F0);
    rd_hold = 0;
    // Swap requested during a clear waits for the clear to finish.
    b.clear_req = 1; cyc(); b.clear_req = 0;
    b.frame_done = 1; cyc(); b.frame_done = 0;
    f0 = b.front_sel;
    pulse_fce(); cyc(); pulse_fce();
    chk("defer_front", b.front_sel, f0);
    chk("defer_pend", b.swap_pending, 1);
    wait_idle();
    pulse_fce();
    chk("defer_swap", b.front_sel, !f0);
    chk("defer_pend_clr", b.swap_pending, 0);
    rd_hold = 1;
    for (int y = OY; y < OY + VH; y++)
      for (int x = OX; x < OX + VW; x++) begin
        b.ReadX = 10'(x); b.ReadY = 10'(y);
        cyc();
      end
    rd_hold = 0;
    f0 = b.front_sel;
    pulse_fce();
    chk("no_done_no_swap", b.front_sel, f0);
    // Reset in the middle of a clear.
    b.clear_req = 1; cyc(); b.clear_req = 0;
    repeat (DEPTH / 2) cyc();
    @(posedge Clk);
    #3 Reset_n = 0;
    #1 chk("rst_mid_busy", b.clear_busy, 0);
    repeat (2) cyc();
    Reset_n = 1;
    chk("rst_mid_front", b.front_sel, 0);
    cyc();
    clear_run("clear_len_after_rst");
    for (int i = 0; i < 3000; i++) begin
      b.draw_valid = 1'($urandom_range(1));
      b.DrawX = 10'(OX - 2 + $urandom_range(VW + 3));
      b.DrawY = 10'(OY - 2 + $urandom_range(VH + 3));
      b.draw_data = $urandom_range(7) == 0 ? KEY : 24'($urandom);
      b.frame_done = $urandom_range(39) == 0;
      b.frame_clk_rising_edge = $urandom_range(24) == 0;
      b.clear_req = $urandom_range(299) == 0;
      cyc();
    end
    {b.frame_clk_rising_edge, b.frame_done, b.clear_req, b.draw_valid} = '0;
    repeat (5) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/frame_buffer_dbl_param.md
Name: frame_buffer_dbl_param

Overview:
Parametrised double-buffered frame store between the sprite/draw engine and the VGA read path. Drawing always targets the back bank and video reads the front bank. Banks swap only at a frame-clock boundary after the drawer signals frame completion. Adds a configurable viewport, channel depth, colour-key transparency, a hardware back-bank clear engine and a pipelined, bank-coherent read path.

Parameters:
ORIGIN_X, 115, first screen column of the viewport
ORIGIN_Y, 80, first screen row of the viewport
VIEW_W, 410, viewport width in pixels
VIEW_H, 320, viewport height in pixels
CBITS, 4, stored bits per colour channel (1..8); RAM word = 3*CBITS
KEY_COLOR, 24'h000000, draw_data value treated as transparent (never written)
CLEAR_COLOR, 24'h000000, colour written by the clear engine
BORDER_COLOR, 24'hFFFFFF, read_data outside the viewport

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_clk_rising_edge  in  1  one-cycle pulse, frame boundary (swap opportunity)
frame_done  in  1  one-cycle pulse, drawer finished the back frame
clear_req  in  1  one-cycle pulse, start back-bank clear
draw_valid  in  1  draw_data/DrawX/DrawY valid this cycle
DrawX, DrawY  in  10  screen coordinates of the draw pixel
draw_data  in  24  RGB 8:8:8 draw colour
ReadX, ReadY  in  10  screen coordinates of the video read
read_data  out  24  RGB 8:8:8 pixel, 2-cycle latency
front_sel  out  1  bank being displayed (0 = bank0)
swap_pending  out  1  frame_done seen, swap not yet taken
clear_busy  out  1  clear engine running

Behaviour:
- Geometry: DEPTH = VIEW_W*VIEW_H; AW = $clog2(DEPTH). In-window: ORIGIN_X <= X < ORIGIN_X+VIEW_W and ORIGIN_Y <= Y < ORIGIN_Y+VIEW_H. addr = (X-ORIGIN_X) + (Y-ORIGIN_Y)*VIEW_W, computed at AW bits with no truncation.
- Storage: two inferred single-write/single-read synchronous RAMs, DEPTH x 3*CBITS. Contents are not reset.
- Quantise: stored word = {R[7:8-CBITS], G[7:8-CBITS], B[7:8-CBITS]}.
- Draw write to bank !front_sel occurs when draw_valid, in-window, draw_data != KEY_COLOR and clear_busy = 0. Otherwise it is dropped silently; there is no backpressure.
- Clear FSM, states IDLE and CLEAR:
  - IDLE plus clear_req: go to CLEAR, counter = 0, clear_busy = 1 from the next cycle.
  - CLEAR: one write per cycle of quantised CLEAR_COLOR at addr = counter to bank !front_sel. After writing DEPTH-1, return to IDLE and drop clear_busy. Total busy time is DEPTH cycles.
  - clear_req while in CLEAR is ignored.
- Swap logic:
  - swap_pending sets on frame_done.
  - On frame_clk_rising_edge with (swap_pending | frame_done) and clear_busy = 0: toggle front_sel and clear swap_pending in the same edge.
  - frame_done coincident with the edge swaps immediately, with no pending cycle.
  - If clear_busy is 1, the swap is deferred to the first edge after the clear completes.
  - Without frame_done, the banks never swap (a frame is held until drawing finishes).
- Read pipeline:
  - Stage 1 registers addr, the in-window flag and the bank select (front_sel at sample time).
  - Stage 2 registers RAM q and the flags.
  - Output: in-window gives each channel = {stored CBITS, (8-CBITS) zeros}; out-of-window gives BORDER_COLOR.
  - ReadX/ReadY sampled at edge N appear on read_data after edge N+2.
  - A swap between sample and output does not change the bank used for that sample.
- Reset (asynchronous, Reset_n = 0): front_sel = 0, swap_pending = 0, clear_busy = 0, FSM = IDLE, counter = 0, read_data = BORDER_COLOR, pipeline flags = out-of-window. Reset during CLEAR aborts the clear with no further writes. Deassertion is synchronised to Clk by the system.

Test Plan:
- Reset, then Read (114,80), (524,399), (525,399) -> BORDER, pixel, BORDER in order, each 2 cycles after its sample. front_sel = 0 and clear_busy = 0 out of reset.
- CBITS=4: draw (115,80) = 24'hA5C3F0, then frame_done, then edge -> front_sel = 1. Read (115,80) returns 24'hA0C0F0. draw_data = 24'h000000 at the same pixel is not written.
- clear_req, then poll -> clear_busy high for exactly 131200 cycles. Draws during the clear leave no trace. The whole back bank reads CLEAR_COLOR after a swap.
- frame_done during clear_busy, then two edges while busy -> front_sel unchanged and swap_pending = 1. The first edge after the clear ends swaps and clears pending.
- frame_done coincident with frame_clk_rising_edge -> front_sel toggles that edge and swap_pending never asserts. An edge without frame_done -> no swap.
- Assert Reset_n low mid-clear (counter ~1000) -> clear_busy drops immediately. After release, clear_req restarts from address 0.
